// File: rtl/alarm_countdown_if.sv
// Control/status bundle between the alarm countdown and its controller.
// master drives the requests and the divider tick, slave is the countdown.
interface alarm_countdown_if;
  localparam int unsigned SECS_W  = 7;
  localparam int unsigned DIGIT_W = 4;

  logic               tick;
  logic [SECS_W-1:0]  load_secs;
  logic               start;
  logic               hold;
  logic               cancel;
  logic               rate_en;
  logic [SECS_W-1:0]  secs_left;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] ones;
  logic               running;
  logic               expired;
  logic               done;

  modport master (
    output tick, load_secs, start, hold, cancel,
    input  rate_en, secs_left, tens, ones, running, expired, done
  );

  modport slave (
    input  tick, load_secs, start, hold, cancel,
    output rate_en, secs_left, tens, ones, running, expired, done
  );
endinterface

// File: rtl/alarm_countdown.sv
// Entry/exit delay seconds countdown (0..MAX_SECS) with pause, cancel,
// BCD digits for the display and a level plus one-cycle expiry report.
module alarm_countdown #(
  parameter int unsigned MAX_SECS = 99
) (
  input  logic              clock,
  input  logic              reset_n,
  alarm_countdown_if.slave  ctl
);

  localparam int unsigned CW = 7;
  localparam int unsigned DW = 4;
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_SECS);
  localparam logic [CW-1:0] TEN     = CW'(10);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_EXPIRED
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [CW-1:0] load_val;
  logic          done_nx;
  logic          rate_en_q, running_q, expired_q, done_q;

  // Requested load, clamped to the saturation limit.
  always_comb begin
    load_val = ctl.load_secs;
    if (ctl.load_secs > MAX_CNT) load_val = MAX_CNT;
  end

  // Next state, next count and the expiry strobe.
  always_comb begin
    state_nx = state;
    count_nx = count;
    done_nx  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ctl.start) begin
          count_nx = load_val;
          if (load_val == '0) begin
            state_nx = ST_EXPIRED;
            done_nx  = 1'b1;
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (ctl.cancel) begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end else if (ctl.tick && (count != '0)) begin
          count_nx = count - CW'(1);
          if (count == CW'(1)) begin
            state_nx = ST_EXPIRED;
            done_nx  = 1'b1;
          end else if (ctl.hold) begin
            state_nx = ST_PAUSE;
          end
        end else if (ctl.hold) begin
          state_nx = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (ctl.cancel) begin
          state_nx = ST_IDLE;
          count_nx = '0;
        end else if (!ctl.hold) begin
          state_nx = ST_RUN;
        end
      end
      ST_EXPIRED: begin
        count_nx = '0;
        if (ctl.cancel) begin
          state_nx = ST_IDLE;
        end else if (ctl.start) begin
          // Re-arm behaves exactly like a start from IDLE.
          count_nx = load_val;
          if (load_val == '0) begin
            done_nx = 1'b1;
          end else begin
            state_nx = ST_RUN;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        count_nx = '0;
      end
    endcase
  end

  // State, count and registered status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      rate_en_q <= 1'b0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      rate_en_q <= (state_nx == ST_RUN);
      running_q <= (state_nx == ST_RUN) || (state_nx == ST_PAUSE);
      expired_q <= (state_nx == ST_EXPIRED);
      done_q    <= done_nx;
    end
  end

  assign ctl.rate_en   = rate_en_q;
  assign ctl.running   = running_q;
  assign ctl.expired   = expired_q;
  assign ctl.done      = done_q;
  assign ctl.secs_left = count;

  // Display digits follow the count register combinationally.
  always_comb begin
    ctl.tens = DW'(count / TEN);
    ctl.ones = DW'(count % TEN);
  end

endmodule

// File: tb/tb_alarm_countdown.sv
// Randomized and directed bench for alarm_countdown against a spec-level
// model, including a small rate-divider stand-in for the integration run.
module tb_alarm_countdown;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;
  localparam int DIV_C   = 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b1;

  int n_checks = 0;
  int n_pass   = 0;

  int m_mode  = M_IDLE;
  int m_count = 0;
  bit m_done  = 1'b0;

  logic       st = 1'b0, ho = 1'b0, ca = 1'b0, tick_rnd = 1'b0;
  logic [6:0] ld = '0;
  logic       use_div = 1'b0;
  logic       div_pulse;
  int         div_cnt;

  alarm_countdown_if bus ();

  alarm_countdown #(.MAX_SECS(99)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ctl     (bus.slave)
  );

  always #5 clock = ~clock;

  assign bus.tick      = use_div ? div_pulse : tick_rnd;
  assign bus.start     = st;
  assign bus.hold      = ho;
  assign bus.cancel    = ca;
  assign bus.load_secs = ld;

  // Divider with period C+1 that reloads whenever rate_en is low.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 0; div_pulse <= 1'b0;
    end else if (!bus.rate_en) begin
      div_cnt <= 0; div_pulse <= 1'b0;
    end else if (div_cnt == DIV_C - 1) begin
      div_cnt <= DIV_C; div_pulse <= 1'b1;
    end else if (div_cnt == DIV_C) begin
      div_cnt <= 0; div_pulse <= 1'b0;
    end else begin
      div_cnt <= div_cnt + 1; div_pulse <= 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic model_load(input int l);
    m_count = (l > 99) ? 99 : l;
    if (m_count == 0) begin
      m_mode = M_EXP; m_done = 1'b1;
    end else begin
      m_mode = M_RUN;
    end
  endtask

  task automatic model_step(input bit s, input bit h, input bit c, input bit t, input int l);
    m_done = 1'b0;
    case (m_mode)
      M_IDLE: if (s) model_load(l);
      M_RUN: begin
        if (c) begin
          m_mode = M_IDLE; m_count = 0;
        end else if (t) begin
          m_count = m_count - 1;
          if (m_count == 0) begin
            m_mode = M_EXP; m_done = 1'b1;
          end else if (h) begin
            m_mode = M_PAUSE;
          end
        end else if (h) begin
          m_mode = M_PAUSE;
        end
      end
      M_PAUSE: begin
        if (c) begin
          m_mode = M_IDLE; m_count = 0;
        end else if (!h) begin
          m_mode = M_RUN;
        end
      end
      default: begin
        if (c) begin
          m_mode = M_IDLE; m_count = 0;
        end else if (s) begin
          model_load(l);
        end
      end
    endcase
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".secs_left"}, 32'(bus.secs_left), 32'(m_count));
    check({ctx, ".tens"},      32'(bus.tens),      32'(m_count / 10));
    check({ctx, ".ones"},      32'(bus.ones),      32'(m_count % 10));
    check({ctx, ".rate_en"},   32'(bus.rate_en),   32'(m_mode == M_RUN));
    check({ctx, ".running"},   32'(bus.running),   32'(m_mode == M_RUN || m_mode == M_PAUSE));
    check({ctx, ".expired"},   32'(bus.expired),   32'(m_mode == M_EXP));
    check({ctx, ".done"},      32'(bus.done),      32'(m_done));
  endtask

  task automatic drive(input bit s, input bit h, input bit c, input bit t, input int l);
    st = s; ho = h; ca = c; tick_rnd = t; ld = 7'(l);
  endtask

  task automatic step(input string ctx);
    @(posedge clock);
    model_step(st, ho, ca, bus.tick, int'(ld));
    #1;
    check_outputs(ctx);
  endtask

  // Reset lands between edges and must clear the outputs with no clock.
  task automatic async_reset(input string ctx);
    #2;
    reset_n = 1'b0;
    #1;
    m_mode = M_IDLE; m_count = 0; m_done = 1'b0;
    check_outputs(ctx);
    drive(0, 0, 0, 0, 0);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    int n_done;
    int first_dec;
    int exp_at;

    #1 reset_n = 1'b0;
    #1 check_outputs("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // Ticks in IDLE are ignored.
    drive(0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("idle_tick");

    // Basic countdown from 3 with a tick every fourth cycle.
    drive(1, 0, 0, 0, 3);
    step("basic.start");
    n_done = 0;
    for (int i = 0; i < 14; i++) begin
      drive(0, 0, 0, (i % 4) == 3, 0);
      step("basic.run");
      if (bus.done === 1'b1) n_done++;
    end
    check("basic.done_pulses", 32'(n_done), 32'd1);

    // Saturation and BCD.
    drive(0, 0, 1, 0, 0);   step("sat.cancel");
    drive(1, 0, 0, 0, 120); step("sat.load120");
    drive(0, 0, 0, 1, 0);   step("sat.tick");
    drive(0, 0, 1, 0, 0);   step("sat.cancel2");
    drive(1, 0, 0, 0, 40);  step("bcd.load40");
    drive(0, 0, 0, 1, 0);   step("bcd.tick");

    // Pause and resume.
    drive(0, 0, 1, 0, 0);   step("pause.cancel");
    drive(1, 0, 0, 0, 10);  step("pause.load10");
    drive(0, 1, 0, 0, 0);   step("pause.hold");
    drive(0, 1, 0, 1, 0);   step("pause.tick_ignored");
    step("pause.tick_ignored2");
    drive(0, 0, 0, 0, 0);   step("pause.resume");
    drive(0, 1, 0, 1, 0);   step("pause.tick_and_hold");
    drive(0, 0, 0, 0, 0);   step("pause.resume9");

    // Cancel and priorities.
    drive(0, 0, 1, 0, 0);   step("prio.cancel");
    drive(1, 0, 0, 0, 1);   step("prio.load1");
    drive(0, 0, 1, 1, 0);   step("prio.cancel_tick");
    drive(1, 0, 0, 0, 1);   step("prio.load1b");
    drive(0, 0, 0, 1, 0);   step("prio.expire");
    drive(1, 0, 1, 0, 5);   step("prio.cancel_start");
    drive(1, 0, 0, 0, 1);   step("prio.load1c");
    drive(0, 0, 0, 1, 0);   step("prio.expire2");
    drive(1, 0, 0, 0, 5);   step("prio.rearm5");
    drive(0, 0, 0, 0, 0);   step("prio.run5");

    // Zero load expires on the accepting edge.
    drive(0, 0, 1, 0, 0);   step("zero.cancel");
    drive(1, 0, 0, 0, 0);   step("zero.start");
    drive(0, 0, 0, 0, 0);   step("zero.after");

    // Asynchronous reset mid-run at 37.
    drive(1, 0, 0, 0, 37);  step("rst.load37");
    drive(0, 0, 0, 0, 0);   step("rst.run37");
    async_reset("rst.async");
    drive(1, 0, 0, 0, 4);   step("rst.restart");

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      int l;
      l = ($urandom % 4 == 0) ? int'($urandom_range(0, 2)) : int'($urandom_range(0, 127));
      drive(($urandom % 10) == 0, ($urandom % 7) == 0, ($urandom % 40) == 0,
            ($urandom % 3) == 0, l);
      step("rand");
      if (($urandom % 400) == 0) async_reset("rand.reset");
    end

    // Integration with the divider stand-in at C=4, load 2.
    drive(0, 0, 1, 0, 0);   step("int.cancel");
    drive(0, 0, 0, 0, 0);   step("int.idle");
    use_div = 1'b1;
    drive(1, 0, 0, 0, 2);   step("int.start");
    drive(0, 0, 0, 0, 0);
    first_dec = -1;
    exp_at    = -1;
    for (int k = 1; k <= 40; k++) begin
      step("int.run");
      if (first_dec < 0 && bus.secs_left == 7'd1) first_dec = k;
      if (exp_at < 0 && bus.expired === 1'b1) exp_at = k;
    end
    check("int.first_decrement", 32'(first_dec), 32'd5);
    check("int.expiry", 32'(exp_at), 32'd10);
    use_div = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
